// File: rtl/fan_speed_ctrl.sv
// Fan operating logic: OFF/L1/L2/L3 speed FSM, auto-off seconds timer, and glitch-free 8-bit PWM.
// Optional build macro FAN_SOFTSTART_EN ramps the PWM duty up by DUTY_STEP per period on increases.
module fan_speed_ctrl #(
  parameter int PWM_DIV   = 390,
  parameter int SEC_TICKS = 100000000,
  parameter int DUTY_L1   = 64,
  parameter int DUTY_L2   = 128,
  parameter int DUTY_L3   = 192,
  parameter int DUTY_STEP = 8
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       btn_speed_pe,
  input  logic       btn_timer_pe,
  input  logic       btn_off_pe,
  output logic [1:0] speed_level,
  output logic [1:0] timer_sel,
  output logic [3:0] timer_remaining,
  output logic       fan_on,
  output logic       pwm_out
);

  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int SEC_W = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_L1  = 2'd1,
    S_L2  = 2'd2,
    S_L3  = 2'd3
  } speed_t;

  speed_t           state;
  speed_t           state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [SEC_W-1:0] sec_cnt;
  logic [7:0]       pwm_cnt;
  logic [7:0]       active_duty;
  logic [7:0]       target_duty;
  logic [7:0]       duty_nxt;
  logic [8:0]       duty_sum;
  logic [1:0]       tsel_inc;
  logic [3:0]       preset_secs;
  logic             pwm_tick;
  logic             period_end;
  logic             sec_tick;
  logic             expire;
  logic             go_off;
  logic             timer_press;

  // The speed state is the level itself, so speed_level doubles as the FSM debug view.
  assign speed_level = state;

  always_comb begin
    pwm_tick    = (div_cnt == DIV_W'(PWM_DIV - 1));
    period_end  = pwm_tick && (pwm_cnt == 8'hFF);
    sec_tick    = (timer_sel != 2'd0) && (sec_cnt == SEC_W'(SEC_TICKS - 1));
    expire      = sec_tick && (timer_remaining == 4'd1);
    // Every route to OFF shares one clear path; the off button and expiry outrank the speed press.
    go_off      = btn_off_pe || expire || (btn_speed_pe && (state == S_L3));
    timer_press = btn_timer_pe && (state != S_OFF);
    tsel_inc    = timer_sel + 2'd1;

    state_nxt = state;
    if (go_off) begin
      state_nxt = S_OFF;
    end else if (btn_speed_pe) begin
      case (state)
        S_OFF:   state_nxt = S_L1;
        S_L1:    state_nxt = S_L2;
        default: state_nxt = S_L3;
      endcase
    end

    case (tsel_inc)
      2'd1:    preset_secs = 4'd5;
      2'd2:    preset_secs = 4'd10;
      2'd3:    preset_secs = 4'd15;
      default: preset_secs = 4'd0;
    endcase

    case (state)
      S_L1:    target_duty = 8'(DUTY_L1);
      S_L2:    target_duty = 8'(DUTY_L2);
      S_L3:    target_duty = 8'(DUTY_L3);
      default: target_duty = 8'd0;
    endcase

    duty_sum = {1'b0, active_duty} + 9'(DUTY_STEP);
`ifdef FAN_SOFTSTART_EN
    if ((target_duty > active_duty) && (duty_sum < {1'b0, target_duty}))
      duty_nxt = duty_sum[7:0];
    else
      duty_nxt = target_duty;
`else
    duty_nxt = target_duty;
`endif
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state           <= S_OFF;
      timer_sel       <= 2'd0;
      timer_remaining <= 4'd0;
      fan_on          <= 1'b0;
      pwm_out         <= 1'b0;
      div_cnt         <= '0;
      sec_cnt         <= '0;
      pwm_cnt         <= 8'd0;
      active_duty     <= 8'd0;
    end else begin
      state  <= state_nxt;
      fan_on <= (state_nxt != S_OFF);

      div_cnt <= pwm_tick ? '0 : div_cnt + DIV_W'(1);
      if (pwm_tick)
        pwm_cnt <= pwm_cnt + 8'd1;

      // Duty only changes at the period boundary, except that OFF drops it at once.
      if (go_off)
        active_duty <= 8'd0;
      else if (period_end)
        active_duty <= duty_nxt;

      pwm_out <= (state_nxt != S_OFF) && (pwm_cnt < active_duty);

      if (go_off) begin
        timer_sel       <= 2'd0;
        timer_remaining <= 4'd0;
        sec_cnt         <= '0;
      end else if (timer_press) begin
        timer_sel       <= tsel_inc;
        timer_remaining <= preset_secs;
        sec_cnt         <= '0;
      end else if (sec_tick) begin
        timer_remaining <= timer_remaining - 4'd1;
        sec_cnt         <= '0;
      end else if (timer_sel != 2'd0) begin
        sec_cnt <= sec_cnt + SEC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl with PWM_DIV=1 and SEC_TICKS=10.
module tb_fan_speed_ctrl;

`ifdef FAN_SOFTSTART_EN
  localparam int SETTLE  = 4500;
  localparam int L3_NEXT = 136;
`else
  localparam int SETTLE  = 300;
  localparam int L3_NEXT = 192;
`endif

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       btn_speed_pe = 1'b0;
  logic       btn_timer_pe = 1'b0;
  logic       btn_off_pe = 1'b0;
  logic [1:0] speed_level;
  logic [1:0] timer_sel;
  logic [3:0] timer_remaining;
  logic       fan_on;
  logic       pwm_out;

  int n_cmp = 0;
  int n_err = 0;

  fan_speed_ctrl #(
    .PWM_DIV(1), .SEC_TICKS(10), .DUTY_L1(64), .DUTY_L2(128), .DUTY_L3(192), .DUTY_STEP(8)
  ) dut (
    .clk(clk), .reset_p(reset_p),
    .btn_speed_pe(btn_speed_pe), .btn_timer_pe(btn_timer_pe), .btn_off_pe(btn_off_pe),
    .speed_level(speed_level), .timer_sel(timer_sel), .timer_remaining(timer_remaining),
    .fan_on(fan_on), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pulse on any mix of buttons; returns on the negedge after the sampling edge.
  task automatic pulse(input logic s, input logic t, input logic o);
    @(negedge clk);
    btn_speed_pe = s; btn_timer_pe = t; btn_off_pe = o;
    @(negedge clk);
    btn_speed_pe = 1'b0; btn_timer_pe = 1'b0; btn_off_pe = 1'b0;
  endtask

  task automatic find_rise(input string tag);
    logic prev;
    bit   found = 0;
    for (int i = 0; i < 600; i++) begin
      prev = pwm_out;
      @(negedge clk);
      if (!prev && pwm_out) begin
        found = 1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Samples pwm_out on n negedges starting with the current one; optional speed press at index press_at.
  task automatic count_high(input int n, input int press_at, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      btn_speed_pe = (i == press_at);
      hi += int'(pwm_out);
      @(negedge clk);
    end
    btn_speed_pe = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_speed"}, 32'(speed_level), 32'd0);
    check({tag, "_tsel"},  32'(timer_sel), 32'd0);
    check({tag, "_trem"},  32'(timer_remaining), 32'd0);
    check({tag, "_fan"},   32'(fan_on), 32'd0);
    check({tag, "_pwm"},   32'(pwm_out), 32'd0);
  endtask

  initial begin
    int hi;
    logic [1:0] exp_speed [4];
    exp_speed[0] = 2'd1; exp_speed[1] = 2'd2; exp_speed[2] = 2'd3; exp_speed[3] = 2'd0;

    // Reset state
    wait_clk(3);
    check_all_zero("reset");
    reset_p = 1'b0;
    wait_clk(2);

    // Speed cycling, each change visible one clock after its pulse
    for (int k = 0; k < 4; k++) begin
      pulse(1'b1, 1'b0, 1'b0);
      check($sformatf("cycle%0d_speed", k), 32'(speed_level), 32'(exp_speed[k]));
      check($sformatf("cycle%0d_fan", k), 32'(fan_on), 32'(exp_speed[k] != 2'd0));
      wait_clk(19);
    end

    // L2 steady duty, then mid-period switch to L3
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check("l2_speed", 32'(speed_level), 32'd2);
    wait_clk(SETTLE);
    count_high(256, -1, hi);
    check("l2_duty", 32'(hi), 32'd128);
    find_rise("l2_rise");
    count_high(256, 50, hi);
    check("l3_switch_period", 32'(hi), 32'd128);
    check("l3_speed", 32'(speed_level), 32'd3);
    count_high(256, -1, hi);
    check("l3_next_period", 32'(hi), 32'(L3_NEXT));

    // Off button, then L1 with a 10 s timer running to expiry
    pulse(1'b0, 1'b0, 1'b1);
    check("off_speed", 32'(speed_level), 32'd0);
    check("off_pwm", 32'(pwm_out), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("t10_sel", 32'(timer_sel), 32'd2);
    check("t10_rem", 32'(timer_remaining), 32'd10);
    wait_clk(49);
    check("t10_mid_rem", 32'(timer_remaining), 32'd6);
    wait_clk(50);
    check("t10_last_rem", 32'(timer_remaining), 32'd1);
    check("t10_last_speed", 32'(speed_level), 32'd1);
    wait_clk(1);
    check_all_zero("t10_expired");

    // Timer press ignored while OFF; OFF with speed+timer gives L1 and no timer
    pulse(1'b0, 1'b1, 1'b0);
    check("off_timer_sel", 32'(timer_sel), 32'd0);
    check("off_timer_rem", 32'(timer_remaining), 32'd0);
    pulse(1'b1, 1'b1, 1'b0);
    check("off_both_speed", 32'(speed_level), 32'd1);
    check("off_both_tsel", 32'(timer_sel), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("l3_t5_sel", 32'(timer_sel), 32'd1);
    check("l3_t5_rem", 32'(timer_remaining), 32'd5);
    pulse(1'b1, 1'b1, 1'b0);
    check("wrap_both_speed", 32'(speed_level), 32'd0);
    check("wrap_both_tsel", 32'(timer_sel), 32'd0);
    check("wrap_both_trem", 32'(timer_remaining), 32'd0);

    // Off button on the expiry edge
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("exp_off_rem5", 32'(timer_remaining), 32'd5);
    wait_clk(49);
    check("exp_off_rem1", 32'(timer_remaining), 32'd1);
    btn_off_pe = 1'b1;
    @(negedge clk);
    btn_off_pe = 1'b0;
    check_all_zero("exp_off");
    count_high(20, -1, hi);
    check("exp_off_quiet", 32'(hi), 32'd0);

    // Off plus speed on the expiry edge
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    wait_clk(49);
    check("exp_offspd_rem1", 32'(timer_remaining), 32'd1);
    btn_off_pe = 1'b1; btn_speed_pe = 1'b1;
    @(negedge clk);
    btn_off_pe = 1'b0; btn_speed_pe = 1'b0;
    check_all_zero("exp_offspd");
    count_high(20, -1, hi);
    check("exp_offspd_quiet", 32'(hi), 32'd0);

    // OFF->L1 per-period duty (ramps with soft start), then async reset mid-period
    pulse(1'b1, 1'b0, 1'b0);
    find_rise("ramp_rise");
    for (int k = 0; k < 8; k++) begin
      count_high(256, -1, hi);
`ifdef FAN_SOFTSTART_EN
      check($sformatf("ramp%0d", k), 32'(hi), 32'(8 * (k + 1)));
`else
      check($sformatf("ramp%0d", k), 32'(hi), 32'd64);
`endif
    end
    pulse(1'b0, 1'b1, 1'b0);
    wait_clk(37);
    #2 reset_p = 1'b1;
    #1 check_all_zero("async_reset");
    wait_clk(2);
    reset_p = 1'b0;
    wait_clk(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fan_speed_ctrl.md
Name: fan_speed_ctrl

Overview:
Consumes the single-cycle, debounced button pulses produced by the button-input stage and runs the fan's operating logic. A speed state machine cycles OFF/L1/L2/L3, and an auto-off timer counts down in seconds. A glitch-free PWM output drives the motor. Sits directly downstream of the button controllers and upstream of the motor driver pin and display logic.

Parameters:
PWM_DIV, 390, clk cycles per PWM step tick (8-bit PWM, 256 steps per period)
SEC_TICKS, 100000000, clk cycles per timer second
DUTY_L1, 64, PWM duty for level 1 (out of 256)
DUTY_L2, 128, PWM duty for level 2
DUTY_L3, 192, PWM duty for level 3
DUTY_STEP, 8, soft-start increment per PWM period (used only with FAN_SOFTSTART_EN)

Ports:
clk  in  1  system clock
reset_p  in  1  reset
btn_speed_pe  in  1  one-cycle pulse: advance speed
btn_timer_pe  in  1  one-cycle pulse: advance timer preset
btn_off_pe  in  1  one-cycle pulse: force OFF
speed_level  out  2  0=OFF, 1..3=level
timer_sel  out  2  0=none, 1=5 s, 2=10 s, 3=15 s
timer_remaining  out  4  seconds left; 0 when no timer
fan_on  out  1  high when speed_level != 0
pwm_out  out  1  registered PWM to motor driver

Behaviour:
- Reset is asynchronous, active-high, on reset_p; clock is clk. All logic is posedge clk.
- Reset values: speed_level=0, timer_sel=0, timer_remaining=0, fan_on=0, pwm_out=0. Internal PWM counter, prescalers, and active duty are also 0.
- Input pulses are 1 clk wide. Each registered output updates on the clk edge that samples the pulse (visible the next cycle).
- Speed FSM: OFF->L1->L2->L3->OFF on btn_speed_pe. btn_off_pe forces OFF from any state.
- Timer preset: btn_timer_pe cycles 0->1->2->3->0 and loads timer_remaining with 0/5/10/15. It also clears the second prescaler. btn_timer_pe is ignored while speed_level==0.
- Countdown: while timer_sel!=0, timer_remaining decrements once per SEC_TICKS clocks. On the tick where it goes 1->0, the fan goes to OFF, timer_sel=0, timer_remaining=0 (timer expiry).
- Any entry to OFF (speed wrap, off button, or expiry) clears timer_sel, timer_remaining, and the second prescaler.
- Same-cycle priority: btn_off_pe > timer expiry > (btn_speed_pe and btn_timer_pe, both applied).
  - If speed wraps L3->OFF in the same cycle as a timer press, the OFF clear wins and the timer stays 0.
  - If the fan is OFF, a speed press and a timer press in the same cycle give L1 with timer 0, because the timer press is evaluated against the pre-press state.
- PWM:
  - Prescaler generates a tick every PWM_DIV clocks; an 8-bit pwm_cnt increments on each tick and wraps 255->0.
  - Target duty comes from speed_level (0 when OFF).
  - Active duty loads from target only on the tick where pwm_cnt wraps 255->0, so there are no partial-period glitches.
  - pwm_out <= fan_on && (pwm_cnt < active_duty).
- Going to OFF forces pwm_out low on the next edge and sets active_duty=0 immediately, without waiting for the period boundary.
- Duty 0 gives constant low; no duty value gives constant high.
- Reset asserted mid-period or mid-countdown returns everything to reset values immediately.

Optional Feature:
FAN_SOFTSTART_EN
- With: at each period boundary, active_duty moves toward target by +DUTY_STEP on increases, saturating at target. Decreases still jump to target at the boundary, and OFF is still immediate. OFF->L3 therefore ramps 0->8->16...->192 over 24 periods.
- Without: active_duty jumps to target at the next period boundary.

Test Plan:
(All tests use PWM_DIV=1, SEC_TICKS=10.)
- Reset then 4 btn_speed_pe pulses 20 clk apart -> speed_level 1,2,3,0; fan_on 1,1,1,0; each change visible 1 clk after its pulse.
- L2 steady -> pwm_out high exactly 128 of every 256 clks. Switch to L3 mid-period -> current period finishes at 128 high, next period 192 high.
- L1, btn_timer_pe x2 -> timer_sel=2, timer_remaining=10. After 100 clks remaining reaches 0, speed_level=0, pwm_out=0 on the next edge.
- Fan OFF, btn_timer_pe -> timer_sel stays 0. L3 with timer=1, btn_speed_pe and btn_timer_pe in the same cycle -> speed 0, timer_sel 0.
- btn_off_pe in the same cycle as the expiry tick, and again with btn_speed_pe -> result OFF, all timer fields 0, no glitch high on pwm_out.
- With FAN_SOFTSTART_EN: OFF->L1 -> active duty 8,16,...,64 across 8 periods. Assert reset_p mid-ramp -> all outputs 0 asynchronously.
